// File: rtl/bus_write_decoder.sv
// Write side of the shared datapath bus: owns the architectural
// registers, issues data-memory write strobes and pointer increments.
module bus_write_decoder #(
  parameter int DW = 16,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [DW-1:0] busin,
  input  logic [CW-1:0] write_en,
  input  logic [3:0]    inc_en,
  input  logic          clr_ac,
  output logic [DW-1:0] aa,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] ab,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] am,
  output logic [DW-1:0] an,
  output logic [DW-1:0] bn,
  output logic [DW-1:0] arp,
  output logic [DW-1:0] acp,
  output logic [DW-1:0] bcp,
  output logic [DW-1:0] ac,
  output logic [DW-1:0] ad,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          wr_err
);

  typedef enum logic [3:0] {
    C_IDLE = 4'd0,
    C_AA   = 4'd1,
    C_R2   = 4'd2,
    C_AB   = 4'd3,
    C_IR   = 4'd4,
    C_AM   = 4'd5,
    C_AN   = 4'd6,
    C_BN   = 4'd7,
    C_ARP  = 4'd8,
    C_ACP  = 4'd9,
    C_BCP  = 4'd10,
    C_R1   = 4'd11,
    C_AC   = 4'd12,
    C_AD   = 4'd13,
    C_DM   = 4'd14,
    C_IM   = 4'd15
  } code_e;

  localparam logic [DW-1:0] ONE = DW'(1);

  logic [DW-1:0] r_aa;
  logic [DW-1:0] r_r2;
  logic [DW-1:0] r_ab;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_am;
  logic [DW-1:0] r_an;
  logic [DW-1:0] r_bn;
  logic [DW-1:0] r_arp;
  logic [DW-1:0] r_acp;
  logic [DW-1:0] r_bcp;
  logic [DW-1:0] r_ac;
  logic [DW-1:0] r_ad;
  logic          r_dm_we;
  logic [DW-1:0] r_dm_addr;
  logic [DW-1:0] r_dm_wdata;
  logic          r_wr_err;

  logic [15:0]   w_sel;
  logic          w_rsvd;
  logic [3:0]    w_code;

  logic [DW-1:0] w_aa_nx;
  logic [DW-1:0] w_r2_nx;
  logic [DW-1:0] w_ab_nx;
  logic [DW-1:0] w_ir_nx;
  logic [DW-1:0] w_am_nx;
  logic [DW-1:0] w_an_nx;
  logic [DW-1:0] w_bn_nx;
  logic [DW-1:0] w_arp_nx;
  logic [DW-1:0] w_acp_nx;
  logic [DW-1:0] w_bcp_nx;
  logic [DW-1:0] w_ac_nx;
  logic [DW-1:0] w_ad_nx;
  logic [DW-1:0] w_dm_addr_nx;
  logic [DW-1:0] w_dm_wdata_nx;

  assign w_code = 4'(write_en);

  always_comb begin
    w_sel  = '0;
    w_rsvd = 1'b0;
    unique case (w_code)
      C_IDLE: ;
      C_AA:   w_sel[C_AA]  = 1'b1;
      C_R2:   w_sel[C_R2]  = 1'b1;
      C_AB:   w_sel[C_AB]  = 1'b1;
      C_IR:   w_sel[C_IR]  = 1'b1;
      C_AM:   w_sel[C_AM]  = 1'b1;
      C_AN:   w_sel[C_AN]  = 1'b1;
      C_BN:   w_sel[C_BN]  = 1'b1;
      C_ARP:  w_sel[C_ARP] = 1'b1;
      C_ACP:  w_sel[C_ACP] = 1'b1;
      C_BCP:  w_sel[C_BCP] = 1'b1;
      C_AC:   w_sel[C_AC]  = 1'b1;
      C_AD:   w_sel[C_AD]  = 1'b1;
      C_DM:   w_sel[C_DM]  = 1'b1;
      C_R1:   w_rsvd       = 1'b1;
      C_IM:   w_rsvd       = 1'b1;
      default: ;
    endcase
  end

  // plain registers: bus write or hold
  always_comb begin
    w_aa_nx = w_sel[C_AA] ? busin : r_aa;
    w_r2_nx = w_sel[C_R2] ? busin : r_r2;
    w_ab_nx = w_sel[C_AB] ? busin : r_ab;
    w_ir_nx = w_sel[C_IR] ? busin : r_ir;
    w_am_nx = w_sel[C_AM] ? busin : r_am;
    w_an_nx = w_sel[C_AN] ? busin : r_an;
    w_bn_nx = w_sel[C_BN] ? busin : r_bn;
    w_ad_nx = w_sel[C_AD] ? busin : r_ad;
  end

  // pointers and ac: bus write beats clear beats increment
  always_comb begin
    w_arp_nx = r_arp;
    if (w_sel[C_ARP]) begin
      w_arp_nx = busin;
    end else if (inc_en[0]) begin
      w_arp_nx = r_arp + ONE;
    end

    w_acp_nx = r_acp;
    if (w_sel[C_ACP]) begin
      w_acp_nx = busin;
    end else if (inc_en[1]) begin
      w_acp_nx = r_acp + ONE;
    end

    w_bcp_nx = r_bcp;
    if (w_sel[C_BCP]) begin
      w_bcp_nx = busin;
    end else if (inc_en[2]) begin
      w_bcp_nx = r_bcp + ONE;
    end

    w_ac_nx = r_ac;
    if (w_sel[C_AC]) begin
      w_ac_nx = busin;
    end else if (clr_ac) begin
      w_ac_nx = '0;
    end else if (inc_en[3]) begin
      w_ac_nx = r_ac + ONE;
    end
  end

  always_comb begin
    w_dm_addr_nx  = r_dm_addr;
    w_dm_wdata_nx = r_dm_wdata;
    if (w_sel[C_DM]) begin
      w_dm_addr_nx  = r_aa;
      w_dm_wdata_nx = busin;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_aa       <= '0;
      r_r2       <= '0;
      r_ab       <= '0;
      r_ir       <= '0;
      r_am       <= '0;
      r_an       <= '0;
      r_bn       <= '0;
      r_arp      <= '0;
      r_acp      <= '0;
      r_bcp      <= '0;
      r_ac       <= '0;
      r_ad       <= '0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_aa       <= w_aa_nx;
      r_r2       <= w_r2_nx;
      r_ab       <= w_ab_nx;
      r_ir       <= w_ir_nx;
      r_am       <= w_am_nx;
      r_an       <= w_an_nx;
      r_bn       <= w_bn_nx;
      r_arp      <= w_arp_nx;
      r_acp      <= w_acp_nx;
      r_bcp      <= w_bcp_nx;
      r_ac       <= w_ac_nx;
      r_ad       <= w_ad_nx;
      r_dm_we    <= w_sel[C_DM];
      r_dm_addr  <= w_dm_addr_nx;
      r_dm_wdata <= w_dm_wdata_nx;
      r_wr_err   <= r_wr_err | w_rsvd;
    end
  end

  assign aa       = r_aa;
  assign r2       = r_r2;
  assign ab       = r_ab;
  assign ir       = r_ir;
  assign am       = r_am;
  assign an       = r_an;
  assign bn       = r_bn;
  assign arp      = r_arp;
  assign acp      = r_acp;
  assign bcp      = r_bcp;
  assign ac       = r_ac;
  assign ad       = r_ad;
  assign dm_we    = r_dm_we;
  assign dm_addr  = r_dm_addr;
  assign dm_wdata = r_dm_wdata;
  assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_bus_write_decoder.sv
// Directed bench for bus_write_decoder with a code-indexed
// register-file model checked every cycle.
module tb_bus_write_decoder;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] busin = '0;
  logic [3:0]  write_en = '0;
  logic [3:0]  inc_en = '0;
  logic        clr_ac = 1'b0;
  logic [15:0] aa, r2, ab, ir, am, an, bn;
  logic [15:0] arp, acp, bcp, ac, ad;
  logic        dm_we;
  logic [15:0] dm_addr, dm_wdata;
  logic        wr_err;

  int nvec = 0;
  int nerr = 0;

  bus_write_decoder #(.DW(16), .CW(4)) dut (
    .clock(clock), .rst_n(rst_n),
    .busin(busin), .write_en(write_en),
    .inc_en(inc_en), .clr_ac(clr_ac),
    .aa(aa), .r2(r2), .ab(ab), .ir(ir),
    .am(am), .an(an), .bn(bn),
    .arp(arp), .acp(acp), .bcp(bcp),
    .ac(ac), .ad(ad),
    .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .wr_err(wr_err)
  );

  always #5 clock = ~clock;

  // model: register file indexed by destination code
  logic [15:0][15:0] m = '0;
  logic        m_we = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wd = '0;
  logic        m_err = 1'b0;
  logic        m_dmseen = 1'b0;

  function automatic bit is_reg(input int k);
    return (k >= 1 && k <= 10) || k == 12 || k == 13;
  endfunction

  function automatic logic [15:0][15:0] nxt(
    input logic [15:0][15:0] cur, input logic [15:0] d,
    input logic [3:0] we, input logic [3:0] inc, input logic clr);
    logic [15:0][15:0] n;
    int icode [4];
    icode = '{8, 9, 10, 12};
    n = cur;
    for (int i = 0; i < 4; i++)
      if (inc[i]) n[icode[i]] = cur[icode[i]] + 16'd1;
    if (clr) n[12] = 16'h0000;
    if (is_reg(int'(we))) n[we] = d;
    return n;
  endfunction

  always @(posedge clock) begin
    if (!rst_n) begin
      m <= '0; m_we <= 1'b0; m_addr <= '0;
      m_wd <= '0; m_err <= 1'b0; m_dmseen <= 1'b0;
    end else begin
      m <= nxt(m, busin, write_en, inc_en, clr_ac);
      m_we <= (write_en == 4'd14);
      if (write_en == 4'd14) begin
        m_addr <= m[1]; m_wd <= busin; m_dmseen <= 1'b1;
      end
      if (write_en == 4'd11 || write_en == 4'd15) m_err <= 1'b1;
    end
  end

  function automatic logic [15:0] dut_reg(input int k);
    case (k)
      1: return aa;   2: return r2;   3: return ab;
      4: return ir;   5: return am;   6: return an;
      7: return bn;   8: return arp;  9: return acp;
      10: return bcp; 12: return ac;  13: return ad;
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int k = 1; k <= 13; k++)
      if (is_reg(k)) chk($sformatf("reg%0d", k), dut_reg(k), m[k]);
    chk("dm_we", 16'(dm_we), 16'(m_we));
    chk("wr_err", 16'(wr_err), 16'(m_err));
    if (m_we || !m_dmseen) begin
      chk("dm_addr", dm_addr, m_addr);
      chk("dm_wdata", dm_wdata, m_wd);
    end
  end

  task automatic apply(input logic [15:0] d, input logic [3:0] we,
                       input logic [3:0] inc, input logic clr,
                       input logic rn);
    busin = d; write_en = we; inc_en = inc;
    clr_ac = clr; rst_n = rn;
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    apply(16'h0, 4'd0, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      apply(16'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'b0);
    chk("rst_aa", aa, 16'h0);
    chk("rst_ac", ac, 16'h0);
    chk("rst_err", 16'(wr_err), 16'h0);
    chk("rst_dmwe", 16'(dm_we), 16'h0);
    idle(); idle();
    chk("post_rst_r2", r2, 16'h0);
    chk("post_rst_dmaddr", dm_addr, 16'h0);

    for (int k = 1; k <= 13; k++) begin
      if (k == 11) continue;
      apply(16'hA500 + 16'(k), 4'(k), 4'h0, 1'b0, 1'b1);
      chk($sformatf("walk%0d", k), dut_reg(k), 16'hA500 + 16'(k));
    end
    idle();

    apply(16'h0040, 4'd1, 4'h0, 1'b0, 1'b1);
    apply(16'h1234, 4'd14, 4'h0, 1'b0, 1'b1);
    chk("dm_we1", 16'(dm_we), 16'h1);
    chk("dm_addr1", dm_addr, 16'h0040);
    chk("dm_wdata1", dm_wdata, 16'h1234);
    idle();
    chk("dm_we_off", 16'(dm_we), 16'h0);
    apply(16'h0001, 4'd14, 4'h0, 1'b0, 1'b1);
    chk("b2b_we_a", 16'(dm_we), 16'h1);
    apply(16'h0002, 4'd14, 4'h0, 1'b0, 1'b1);
    chk("b2b_we_b", 16'(dm_we), 16'h1);
    chk("b2b_wdata", dm_wdata, 16'h0002);
    idle();
    chk("b2b_off", 16'(dm_we), 16'h0);

    apply(16'hFFFF, 4'd8, 4'h0, 1'b0, 1'b1);
    apply(16'h0000, 4'd0, 4'h1, 1'b0, 1'b1);
    chk("arp_wrap", arp, 16'h0000);
    apply(16'h0007, 4'd9, 4'h2, 1'b0, 1'b1);
    chk("acp_wr_pri", acp, 16'h0007);
    apply(16'h0005, 4'd12, 4'h0, 1'b0, 1'b1);
    apply(16'h0000, 4'd0, 4'h8, 1'b1, 1'b1);
    chk("ac_clr_pri", ac, 16'h0000);
    apply(16'h0000, 4'd0, 4'hF, 1'b0, 1'b1);
    chk("inc_all_acp", acp, 16'h0008);
    chk("inc_all_bcp", bcp, 16'hA50B);
    apply(16'h0055, 4'd1, 4'h1, 1'b0, 1'b1);
    chk("wr_inc_aa", aa, 16'h0055);
    chk("wr_inc_arp", arp, 16'h0002);
    apply(16'h0033, 4'd3, 4'h0, 1'b0, 1'b1);
    apply(16'h0033, 4'd3, 4'h0, 1'b0, 1'b1);
    chk("hold_ab", ab, 16'h0033);

    chk("err_pre", 16'(wr_err), 16'h0);
    apply(16'h9999, 4'd11, 4'h0, 1'b0, 1'b1);
    chk("err_11", 16'(wr_err), 16'h1);
    chk("err_11_aa", aa, 16'h0055);
    apply(16'h8888, 4'd15, 4'h0, 1'b0, 1'b1);
    apply(16'h0003, 4'd2, 4'h0, 1'b0, 1'b1);
    chk("err_sticky", 16'(wr_err), 16'h1);
    chk("err_r2", r2, 16'h0003);

    apply(16'hBEEF, 4'd14, 4'h0, 1'b0, 1'b1);
    apply(16'hBEEF, 4'd2, 4'hF, 1'b0, 1'b0);
    chk("rstact_r2", r2, 16'h0);
    chk("rstact_arp", arp, 16'h0);
    chk("rstact_acp", acp, 16'h0);
    chk("rstact_bcp", bcp, 16'h0);
    chk("rstact_ac", ac, 16'h0);
    chk("rstact_dmwe", 16'(dm_we), 16'h0);
    chk("rstact_err", 16'(wr_err), 16'h0);
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
